// File: rtl/reg_expect_checker.sv
// Register-file snooping scoreboard: shadows architectural registers and runs a
// loaded table of (flag, register, expected) checks, reporting pass/fail/timeout.
module reg_expect_checker #(
  parameter int XLEN           = 32,
  parameter int NUM_REGS       = 32,
  parameter int FLAG_REG       = 20,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 50000,
  localparam int AW = $clog2(NUM_REGS),
  localparam int IW = $clog2(DEPTH),
  localparam int CW = IW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rf_we,
  input  logic [AW-1:0]   rf_waddr,
  input  logic [XLEN-1:0] rf_wdata,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [XLEN-1:0] cfg_flag,
  input  logic [AW-1:0]   cfg_reg,
  input  logic [XLEN-1:0] cfg_expected,
  input  logic            clear,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic            timeout,
  output logic [IW-1:0]   fail_idx,
  output logic [XLEN-1:0] fail_got,
  output logic [XLEN-1:0] fail_expected,
  output logic [CW-1:0]   num_passed
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_FLAG, S_CHECK, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] shadow_q [NUM_REGS];
  logic [XLEN-1:0] shadow_d [NUM_REGS];
  logic [XLEN-1:0] tbl_flag_q [DEPTH];
  logic [XLEN-1:0] tbl_flag_d [DEPTH];
  logic [AW-1:0]   tbl_reg_q [DEPTH];
  logic [AW-1:0]   tbl_reg_d [DEPTH];
  logic [XLEN-1:0] tbl_exp_q [DEPTH];
  logic [XLEN-1:0] tbl_exp_d [DEPTH];
  logic [CW-1:0]   count_q, count_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            pass_q, pass_d;
  logic            fail_q, fail_d;
  logic            timeout_q, timeout_d;
  logic [IW-1:0]   fail_idx_q, fail_idx_d;
  logic [XLEN-1:0] fail_got_q, fail_got_d;
  logic [XLEN-1:0] fail_exp_q, fail_exp_d;
  logic [CW-1:0]   num_passed_q, num_passed_d;
  logic            load_hs;
  logic [XLEN-1:0] chk_got;

  assign cfg_ready     = (state_q == S_IDLE) && (count_q < CW'(DEPTH));
  assign load_hs       = cfg_valid && cfg_ready;
  assign chk_got       = shadow_q[tbl_reg_q[idx_q]];
  assign busy          = (state_q == S_WAIT_FLAG) || (state_q == S_CHECK);
  assign done          = (state_q == S_DONE);
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign timeout       = timeout_q;
  assign fail_idx      = fail_idx_q;
  assign fail_got      = fail_got_q;
  assign fail_expected = fail_exp_q;
  assign num_passed    = num_passed_q;

  always_comb begin
    shadow_d     = shadow_q;
    tbl_flag_d   = tbl_flag_q;
    tbl_reg_d    = tbl_reg_q;
    tbl_exp_d    = tbl_exp_q;
    count_d      = count_q;
    state_d      = state_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    timeout_d    = timeout_q;
    fail_idx_d   = fail_idx_q;
    fail_got_d   = fail_got_q;
    fail_exp_d   = fail_exp_q;
    num_passed_d = num_passed_q;

    if (rf_we && (rf_waddr != '0)) shadow_d[rf_waddr] = rf_wdata;

    if (load_hs) begin
      tbl_flag_d[count_q[IW-1:0]] = cfg_flag;
      tbl_reg_d[count_q[IW-1:0]]  = cfg_reg;
      tbl_exp_d[count_q[IW-1:0]]  = cfg_expected;
      count_d = count_q + CW'(1);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pass_d       = 1'b0;
          fail_d       = 1'b0;
          timeout_d    = 1'b0;
          fail_idx_d   = '0;
          fail_got_d   = '0;
          fail_exp_d   = '0;
          num_passed_d = '0;
          idx_d        = '0;
          timer_d      = '0;
          // count_d already includes a same-cycle load handshake
          if (count_d == '0) begin
            state_d = S_DONE;
            pass_d  = 1'b1;
          end else begin
            state_d = S_WAIT_FLAG;
          end
        end
      end
      S_WAIT_FLAG: begin
        if (shadow_q[FLAG_REG] == tbl_flag_q[idx_q]) begin
          state_d = S_CHECK;
        end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TIMER_LAST)) begin
          state_d    = S_DONE;
          timeout_d  = 1'b1;
          fail_d     = 1'b1;
          fail_idx_d = idx_q;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_CHECK: begin
        if (chk_got == tbl_exp_q[idx_q]) begin
          num_passed_d = num_passed_q + CW'(1);
          if ((CW'(idx_q) + CW'(1)) == count_q) begin
            state_d = S_DONE;
            pass_d  = 1'b1;
          end else begin
            idx_d   = idx_q + IW'(1);
            timer_d = '0;
            state_d = S_WAIT_FLAG;
          end
        end else begin
          state_d    = S_DONE;
          fail_d     = 1'b1;
          fail_idx_d = idx_q;
          fail_got_d = chk_got;
          fail_exp_d = tbl_exp_q[idx_q];
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clear) begin
      state_d      = S_IDLE;
      count_d      = '0;
      idx_d        = '0;
      timer_d      = '0;
      pass_d       = 1'b0;
      fail_d       = 1'b0;
      timeout_d    = 1'b0;
      fail_idx_d   = '0;
      fail_got_d   = '0;
      fail_exp_d   = '0;
      num_passed_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_flag_q[i] <= '0;
        tbl_reg_q[i]  <= '0;
        tbl_exp_q[i]  <= '0;
      end
      state_q      <= S_IDLE;
      count_q      <= '0;
      idx_q        <= '0;
      timer_q      <= '0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
      fail_idx_q   <= '0;
      fail_got_q   <= '0;
      fail_exp_q   <= '0;
      num_passed_q <= '0;
    end else begin
      shadow_q     <= shadow_d;
      tbl_flag_q   <= tbl_flag_d;
      tbl_reg_q    <= tbl_reg_d;
      tbl_exp_q    <= tbl_exp_d;
      state_q      <= state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      timeout_q    <= timeout_d;
      fail_idx_q   <= fail_idx_d;
      fail_got_q   <= fail_got_d;
      fail_exp_q   <= fail_exp_d;
      num_passed_q <= num_passed_d;
    end
  end

endmodule

// File: tb/tb_reg_expect_checker.sv
// Bench for reg_expect_checker: directed scenarios, a vector table and
// randomized runs scored against a sequential list-evaluation model.
module tb_reg_expect_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_flag;
  logic [4:0]  cfg_reg;
  logic [31:0] cfg_expected;
  logic        clear, start;
  logic        busy, done, pass, fail, timeout;
  logic [3:0]  fail_idx;
  logic [31:0] fail_got, fail_expected;
  logic [4:0]  num_passed;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [31:0] m_shadow [32];

  typedef struct {
    logic [4:0]  pre_reg;
    logic [31:0] pre_val;
    logic [31:0] flag;
    logic [4:0]  ent_reg;
    logic [31:0] ent_exp;
    logic        exp_pass;
    logic [31:0] exp_got;
  } vec_t;
  vec_t vecs [7];

  reg_expect_checker #(.TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_flag(cfg_flag), .cfg_reg(cfg_reg),
    .cfg_expected(cfg_expected), .clear(clear), .start(start), .busy(busy), .done(done),
    .pass(pass), .fail(fail), .timeout(timeout), .fail_idx(fail_idx), .fail_got(fail_got),
    .fail_expected(fail_expected), .num_passed(num_passed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic snoop(input logic [4:0] a, input logic [31:0] d);
    rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
    tick();
    rf_we = 1'b0;
    if (a != 0) m_shadow[a] = d;
  endtask

  task automatic load(input logic [31:0] f, input logic [4:0] r, input logic [31:0] e);
    cfg_valid = 1'b1; cfg_flag = f; cfg_reg = r; cfg_expected = e;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk("done_reached", done, 1);
  endtask

  initial begin
    int k;
    rst = 1'b0; rf_we = 0; rf_waddr = 0; rf_wdata = 0; cfg_valid = 0;
    cfg_flag = 0; cfg_reg = 0; cfg_expected = 0; clear = 0; start = 0;
    for (int i = 0; i < 32; i++) m_shadow[i] = 0;

    vecs[0] = '{5'd3,  32'hAA,       32'd11, 5'd3,  32'hAA,       1'b1, 32'h0};
    vecs[1] = '{5'd3,  32'hAB,       32'd12, 5'd3,  32'hAA,       1'b0, 32'hAB};
    vecs[2] = '{5'd0,  32'd5,        32'd13, 5'd0,  32'd0,        1'b1, 32'h0};
    vecs[3] = '{5'd0,  32'd5,        32'd14, 5'd0,  32'd5,        1'b0, 32'h0};
    vecs[4] = '{5'd31, 32'hFFFFFFFF, 32'd15, 5'd31, 32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[5] = '{5'd5,  32'd1,        32'd16, 5'd20, 32'd16,       1'b1, 32'h0};
    vecs[6] = '{5'd5,  32'd1,        32'd17, 5'd20, 32'd18,       1'b0, 32'd17};

    #12;
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_status", {busy, done, pass, fail, timeout}, 0);
    chk("rst_num_passed", num_passed, 0);
    #2 rst = 1'b1;
    tick();

    // Three-entry pass run with spaced snoops
    load(1, 1, 300); load(2, 1, 500); load(2, 2, 100);
    do_start();
    chk("a_busy", busy, 1);
    snoop(1, 300);  ticks(3);
    snoop(20, 1);   ticks(3);
    snoop(1, 500);  ticks(3);
    snoop(2, 100);  ticks(3);
    snoop(20, 2);
    wait_done(40);
    chk("a_pass", pass, 1);
    chk("a_num_passed", num_passed, 3);
    ticks(5);
    chk("a_sticky", {done, pass, fail, busy}, 4'b1100);

    // Re-run same table with a bad x1
    snoop(20, 0);
    do_start();
    chk("b_cleared", {done, pass, busy}, 3'b001);
    snoop(1, 299); ticks(3);
    snoop(20, 1);
    wait_done(40);
    chk("b_fail", {pass, fail, timeout}, 3'b010);
    chk("b_fail_idx", fail_idx, 0);
    chk("b_fail_got", fail_got, 299);
    chk("b_fail_exp", fail_expected, 300);
    chk("b_num_passed", num_passed, 0);

    // Timeout; load handshake shares the start cycle
    do_clear();
    cfg_valid = 1'b1; cfg_flag = 7; cfg_reg = 1; cfg_expected = 0; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    chk("c_busy", busy, 1);
    k = 0;
    while (!done && k < 100) begin
      tick();
      k++;
    end
    chk("c_timeout_cycles", k, 50);
    chk("c_flags", {pass, fail, timeout}, 3'b011);
    chk("c_fail_idx", fail_idx, 0);

    // Fill to capacity with 17 offers
    do_clear();
    snoop(20, 9);
    cfg_valid = 1'b1; cfg_flag = 9; cfg_reg = 20; cfg_expected = 9;
    for (int i = 0; i < 17; i++) begin
      chk("d_cfg_ready", cfg_ready, (i < 16) ? 1 : 0);
      tick();
    end
    cfg_valid = 1'b0;
    do_start();
    wait_done(100);
    chk("d_pass", pass, 1);
    chk("d_num_passed", num_passed, 16);

    // Single-entry vector table
    for (int v = 0; v < 7; v++) begin
      do_clear();
      snoop(vecs[v].pre_reg, vecs[v].pre_val);
      snoop(20, vecs[v].flag);
      load(vecs[v].flag, vecs[v].ent_reg, vecs[v].ent_exp);
      do_start();
      wait_done(20);
      chk("t_pass", pass, vecs[v].exp_pass);
      chk("t_fail", fail, !vecs[v].exp_pass);
      chk("t_num_passed", num_passed, vecs[v].exp_pass ? 1 : 0);
      if (!vecs[v].exp_pass) begin
        chk("t_fail_got", fail_got, vecs[v].exp_got);
        chk("t_fail_exp", fail_expected, vecs[v].ent_exp);
      end
    end

    // Empty table
    do_clear();
    chk("e_idle", {cfg_ready, done}, 2'b10);
    do_start();
    chk("e_done_pass", {done, pass, fail}, 3'b110);
    chk("e_num_passed", num_passed, 0);

    // Randomized runs against the list model
    for (int it = 0; it < 30; it++) begin
      int n, m_passed, m_fidx;
      logic m_failed;
      logic [31:0] m_got, m_fgot, m_fexp;
      logic [31:0] e_flag [4];
      logic [4:0]  e_reg [4];
      logic [31:0] e_exp [4];
      do_clear();
      repeat ($urandom_range(3, 6)) snoop(5'($urandom_range(0, 7)), $urandom);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        e_flag[i] = $urandom_range(1, 4);
        e_reg[i]  = ($urandom_range(0, 8) == 8) ? 5'd20 : 5'($urandom_range(0, 7));
        e_exp[i]  = $urandom;
        if ($urandom_range(0, 3) != 0)
          e_exp[i] = (e_reg[i] == 20) ? e_flag[i] : m_shadow[e_reg[i]];
        load(e_flag[i], e_reg[i], e_exp[i]);
      end
      do_start();
      m_failed = 0; m_passed = 0; m_fidx = 0; m_fgot = 0; m_fexp = 0;
      for (int i = 0; i < n; i++) begin
        if (!m_failed) begin
          if (m_shadow[20] != e_flag[i]) snoop(20, e_flag[i]);
          ticks(4);
          m_got = m_shadow[e_reg[i]];
          if (m_got == e_exp[i]) m_passed++;
          else begin
            m_failed = 1; m_fidx = i; m_fgot = m_got; m_fexp = e_exp[i];
          end
        end
      end
      wait_done(40);
      chk("r_pass", pass, !m_failed);
      chk("r_fail", fail, m_failed);
      chk("r_timeout", timeout, 0);
      chk("r_num_passed", num_passed, m_passed);
      if (m_failed) begin
        chk("r_fail_idx", fail_idx, m_fidx);
        chk("r_fail_got", fail_got, m_fgot);
        chk("r_fail_exp", fail_expected, m_fexp);
      end
    end

    // Asynchronous reset in the middle of WAIT_FLAG
    do_clear();
    load(55, 1, 0);
    do_start();
    ticks(3);
    chk("f_busy_before", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("f_async_status", {busy, done, pass, fail, timeout}, 0);
    chk("f_async_cfg_ready", cfg_ready, 1);
    chk("f_async_num_passed", num_passed, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 32; i++) m_shadow[i] = 0;
    tick();
    load(0, 1, 0);
    do_start();
    wait_done(20);
    chk("f_shadow_cleared_pass", {pass, fail}, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
